id_stage_ctrl: RTL and testbench

- Decode-stage controller for the 3/5-stage RISC-V core.
- Holds the one-entry IF→ID pipeline register and decodes the opcode into the 2-bit immediate-format select for the immediate generator.
- Detects load-use hazards against the instruction in EX, inserts bubbles, and applies branch/jump flushes.
- Sits between fetch and execute with valid/ready handshakes on both sides.

---
 rtl/id_stage_ctrl_if.sv | 41 ++++
 rtl/id_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_id_stage_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_ctrl_if.sv
// Handshake and data bundle between fetch, the ID controller and EX.
// slave is the ID controller side; master is the fetch/EX environment.
interface id_stage_ctrl_if #(
  parameter int N = 32
);
  logic         if_valid;
  logic [N-1:0] if_instr;
  logic [N-1:0] if_pc;
  logic         id_ready;
  logic         ex_ready;
  logic         flush;
  logic         ex_is_load;
  logic [4:0]   ex_rd;
  logic         id_valid;
  logic [N-1:0] id_instr;
  logic [N-1:0] id_pc;
  logic [1:0]   imm_sel;
  logic         id_jal;
  logic         id_illegal;
  logic         hazard;

  modport slave (
    input  if_valid, if_instr, if_pc,
    input  ex_ready, flush,
    input  ex_is_load, ex_rd,
    output id_ready, id_valid,
    output id_instr, id_pc,
    output imm_sel, id_jal,
    output id_illegal, hazard
  );

  modport master (
    output if_valid, if_instr, if_pc,
    output ex_ready, flush,
    output ex_is_load, ex_rd,
    input  id_ready, id_valid,
    input  id_instr, id_pc,
    input  imm_sel, id_jal,
    input  id_illegal, hazard
  );
endinterface

// File: rtl/id_stage_ctrl.sv
// ID-stage controller: IF/ID register, imm-format decode, load-use stall.
// Define ID_PERF_CNT_EN to add stall_cnt / flush_cnt outputs.
module id_stage_ctrl #(
  parameter int          N         = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt,
`endif
  id_stage_ctrl_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  logic         r_valid;
  logic [N-1:0] r_instr;
  logic [N-1:0] r_pc;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       bad_op;
  logic [1:0] imm_sel;
  logic       jal;
  logic       hazard;
  logic       id_valid;
  logic       id_ready;
  logic       take;

  assign opcode = r_instr[6:0];
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];

  // Opcode decode: immediate format and source-register usage
  always_comb begin
    imm_sel = 2'd0;
    jal     = 1'b0;
    bad_op  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: use_rs1 = 1'b1;
      OP_SYS:   use_rs1 = ~r_instr[14];
      OP_STORE: begin
        imm_sel = 2'd1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BR: begin
        imm_sel = 2'd2;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: imm_sel = 2'd3;
      OP_JAL:   jal = 1'b1;
      OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default:  bad_op = 1'b1;
    endcase
  end

  // Load-use stall only matters for a real destination register
  assign hazard = r_valid & bus.ex_is_load
                & (bus.ex_rd != 5'd0)
                & ((use_rs1 & (rs1 == bus.ex_rd))
                |  (use_rs2 & (rs2 == bus.ex_rd)));

  assign id_valid = r_valid & ~hazard;
  assign id_ready = ~r_valid | (bus.ex_ready & ~hazard);
  assign take     = bus.if_valid & id_ready;

  assign bus.id_valid   = id_valid;
  assign bus.id_ready   = id_ready;
  assign bus.id_instr   = r_instr;
  assign bus.id_pc      = r_pc;
  assign bus.imm_sel    = imm_sel;
  assign bus.id_jal     = jal;
  assign bus.id_illegal = r_valid & bad_op;
  assign bus.hazard     = hazard;

  // IF/ID register: flush beats a new fetch beat, which beats drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= N'(NOP_INSTR);
      r_pc    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_instr <= N'(NOP_INSTR);
    end else if (take) begin
      r_valid <= 1'b1;
      r_instr <= bus.if_instr;
      r_pc    <= bus.if_pc;
    end else if (id_valid & bus.ex_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Stall and squash counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard)
        stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush & r_valid)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed self-checking bench for id_stage_ctrl.
// Inputs change #1 after posedge; outputs checked before the next edge.
module tb_id_stage_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SW   = 32'h0020_A023;
  localparam logic [31:0] BEQ  = 32'h0020_8063;
  localparam logic [31:0] LUI  = 32'h1234_52B7;
  localparam logic [31:0] ADD  = 32'h0072_8333;
  localparam logic [31:0] ADDI = 32'h00A0_0093;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_stage_ctrl_if #(.N(32)) bus ();

  id_stage_ctrl #(.N(32), .NOP_INSTR(32'h13)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ID_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid   = 1'b0;
    bus.if_instr   = '0;
    bus.if_pc      = '0;
    bus.flush      = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd      = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.ex_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (bus.id_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b want 0", bus.id_valid);
    end
    if (bus.id_instr !== NOP) begin
      fails++;
      $display("FAIL reset_instr got %h want %h", bus.id_instr, NOP);
    end
    if (bus.id_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc got %h want 0", bus.id_pc);
    end
    if (bus.id_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", bus.id_ready);
    end
    if (bus.hazard !== 1'b0 || bus.id_illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_hz_ill got %b%b want 00",
               bus.hazard, bus.id_illegal);
    end
    if (bus.imm_sel !== 2'd0 || bus.id_jal !== 1'b0) begin
      fails++;
      $display("FAIL reset_dec got %0d/%b want 0/0",
               bus.imm_sel, bus.id_jal);
    end
`ifdef ID_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      fails++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0",
               stall_cnt, flush_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] ins [3] = '{SW, BEQ, LUI};
    logic [1:0]  sel [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      bus.if_valid = 1'b1;
      bus.if_instr = ins[i];
      bus.if_pc    = 32'h100 + 32'(4 * i);
      tick();
      checks++;
      if (bus.id_valid !== 1'b1 || bus.imm_sel !== sel[i] ||
          bus.id_instr !== ins[i] ||
          bus.id_pc !== 32'h100 + 32'(4 * i) ||
          bus.id_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_%0d got v%b s%0d %h %h r%b want v1 s%0d %h",
                 i, bus.id_valid, bus.imm_sel, bus.id_instr,
                 bus.id_pc, bus.id_ready, sel[i], ins[i]);
      end
    end
    idle();
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain got %b want 0", bus.id_valid);
    end
  endtask

  task automatic test_load_use();
    bus.if_valid = 1'b1;
    bus.if_instr = ADD;
    bus.if_pc    = 32'h200;
    tick();
    idle();
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = 5'd5;
    #1;
    checks++;
    if (bus.hazard !== 1'b1 || bus.id_valid !== 1'b0 ||
        bus.id_ready !== 1'b0) begin
      fails++;
      $display("FAIL lu_rs1 got h%b v%b r%b want h1 v0 r0",
               bus.hazard, bus.id_valid, bus.id_ready);
    end
    bus.ex_rd = 5'd7;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      fails++;
      $display("FAIL lu_rs2 got %b want 1", bus.hazard);
    end
    bus.ex_rd = 5'd6;
    #1;
    checks++;
    if (bus.hazard !== 1'b0 || bus.id_valid !== 1'b1) begin
      fails++;
      $display("FAIL lu_rd got h%b v%b want h0 v1",
               bus.hazard, bus.id_valid);
    end
    bus.ex_rd = 5'd5;
    tick();
    bus.ex_is_load = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_instr !== ADD ||
        bus.id_pc !== 32'h200 || bus.hazard !== 1'b0) begin
      fails++;
      $display("FAIL lu_replay got v%b %h %h h%b want v1 %h 200 h0",
               bus.id_valid, bus.id_instr, bus.id_pc,
               bus.hazard, ADD);
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin
      fails++;
      $display("FAIL lu_drain got %b want 0", bus.id_valid);
    end
  endtask

  task automatic test_x0();
    bus.if_valid = 1'b1;
    bus.if_instr = ADDI;
    bus.if_pc    = 32'h280;
    tick();
    idle();
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = 5'd0;
    #1;
    checks++;
    if (bus.hazard !== 1'b0 || bus.id_valid !== 1'b1) begin
      fails++;
      $display("FAIL x0 got h%b v%b want h0 v1",
               bus.hazard, bus.id_valid);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    bus.if_valid = 1'b1;
    bus.if_instr = LUI;
    bus.if_pc    = 32'h2C0;
    tick();
    bus.flush    = 1'b1;
    bus.if_instr = ADDI;
    bus.if_pc    = 32'h300;
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP) begin
      fails++;
      $display("FAIL flush got v%b %h want v0 %h",
               bus.id_valid, bus.id_instr, NOP);
    end
    idle();
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP) begin
      fails++;
      $display("FAIL flush_drop got v%b %h want v0 %h",
               bus.id_valid, bus.id_instr, NOP);
    end
`ifdef ID_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
      fails++;
      $display("FAIL perf_cnt got %0d/%0d want 1/1",
               stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h0;
    bus.if_pc    = 32'h400;
    tick();
    bus.if_instr = SW;
    bus.if_pc    = 32'h404;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.id_ready !== 1'b0 || bus.id_valid !== 1'b1 ||
          bus.id_instr !== 32'h0 || bus.id_pc !== 32'h400 ||
          bus.id_illegal !== 1'b1) begin
        fails++;
        $display("FAIL bp_%0d got r%b v%b %h %h i%b want r0 v1 0 400 i1",
                 i, bus.id_ready, bus.id_valid, bus.id_instr,
                 bus.id_pc, bus.id_illegal);
      end
      tick();
    end
    bus.ex_ready = 1'b1;
    tick();
    checks++;
    if (bus.id_instr !== SW || bus.id_pc !== 32'h404 ||
        bus.imm_sel !== 2'd1 || bus.id_illegal !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got %h %h s%0d i%b want %h 404 s1 i0",
               bus.id_instr, bus.id_pc, bus.imm_sel,
               bus.id_illegal, SW);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bus.if_valid = 1'b1;
    bus.if_instr = ADD;
    bus.if_pc    = 32'h500;
    tick();
    idle();
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = 5'd5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP ||
        bus.id_pc !== 32'h0 || bus.hazard !== 1'b0) begin
      fails++;
      $display("FAIL rst_stall got v%b %h %h h%b want v0 %h 0 h0",
               bus.id_valid, bus.id_instr, bus.id_pc,
               bus.hazard, NOP);
    end
    idle();
  endtask

  task automatic test_jal();
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h0000_006F;
    bus.if_pc    = 32'h600;
    tick();
    idle();
    checks++;
    if (bus.id_jal !== 1'b1 || bus.imm_sel !== 2'd0 ||
        bus.id_illegal !== 1'b0) begin
      fails++;
      $display("FAIL jal got j%b s%0d i%b want j1 s0 i0",
               bus.id_jal, bus.imm_sel, bus.id_illegal);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    idle();
    test_reset();
    test_stream();
    test_load_use();
    test_x0();
    test_flush();
    test_backpressure();
    test_jal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
